// File: rtl/ftdnn_dispatch_pkg.sv
// Shared types, constants and the wrapped priority search for the row dispatcher.
package ftdnn_dispatch_pkg;

    typedef enum logic {
        DISP_BCAST   = 1'b0,
        DISP_SCATTER = 1'b1
    } dispatch_mode_e;

    localparam int unsigned STALL_CNT_W = 32;
    localparam int unsigned MAX_ROWS    = 32;
    localparam int unsigned IDX_W       = $clog2(MAX_ROWS);

    // First set bit at or after start, wrapping. A narrower mask zero-extended to
    // MAX_ROWS wraps identically because the padding bits can never match.
    function automatic logic [IDX_W-1:0] next_enabled(input logic [MAX_ROWS-1:0] mask,
                                                      input logic [IDX_W-1:0]    start);
        logic [IDX_W-1:0] idx;
        logic             found;
        next_enabled = start;
        found        = 1'b0;
        for (int unsigned i = 0; i < MAX_ROWS; i++) begin
            idx = start + IDX_W'(i);
            if (!found && mask[idx]) begin
                next_enabled = idx;
                found        = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/ftdnn_sync_fifo.sv
// Shift-register FIFO: entry 0 is always the head, so the head output is a flop.
module ftdnn_sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk_h,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
    localparam int unsigned ADDR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] wr_idx;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = data_q[0];
    assign do_pop  = pop && !empty;
    assign do_push = push && !full;
    assign wr_idx  = do_pop ? (count_q - CNT_W'(1)) : count_q;

    always_ff @(posedge clk_h) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; count_q alone defines which entries are live.
    always_ff @(posedge clk_h) begin
        if (do_pop) begin
            for (int unsigned i = 0; i < DEPTH - 1; i++) begin
                data_q[i] <= data_q[i+1];
            end
        end
        if (do_push) begin
            data_q[ADDR_W'(wr_idx)] <= push_data;
        end
    end

endmodule

// File: rtl/ftdnn_row_dispatch.sv
// Activation/parameter dispatcher to NUM_ROWS conv row blocks (broadcast or scatter).
// Define FTDNN_DISPATCH_PERF_EN to add the stall_cnt performance counter output.
module ftdnn_row_dispatch
    import ftdnn_dispatch_pkg::*;
#(
    parameter int unsigned NUM_ROWS   = 4,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned PARAM_W    = 64,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                   clk_h,
    input  logic                   rst,
    input  logic                   mode,
    input  logic [NUM_ROWS-1:0]    row_en,
    input  logic [DATA_W-1:0]      actbuf_wr_data,
    input  logic                   actbuf_wr_vld,
    output logic                   actbuf_wr_req,
    output logic [DATA_W-1:0]      row_wr_data,
    output logic [NUM_ROWS-1:0]    row_wr_vld,
    input  logic [NUM_ROWS-1:0]    row_wr_req,
    input  logic [PARAM_W-1:0]     sblk_param,
    input  logic                   sblk_param_en,
    input  logic [NUM_ROWS-1:0]    sblk_param_sel,
    output logic [PARAM_W-1:0]     row_param,
    output logic [NUM_ROWS-1:0]    row_param_en,
    input  logic [NUM_ROWS-1:0]    row_status,
    input  logic                   status_clr,
    output logic [NUM_ROWS-1:0]    sblk_status,
    output logic                   all_done
`ifdef FTDNN_DISPATCH_PERF_EN
    ,
    output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

    localparam int unsigned PTR_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic                fifo_full;
    logic                fifo_empty;
    logic [CNT_W-1:0]    fifo_count;
    logic                push;
    logic                pop;

    logic [NUM_ROWS-1:0] served_q;
    logic [NUM_ROWS-1:0] served_d;
    logic [PTR_W-1:0]    ptr_q;
    logic [PTR_W-1:0]    ptr_d;
    logic [PTR_W-1:0]    target;
    dispatch_mode_e      mode_q;

    // Ready depends only on occupancy; held low while in reset.
    assign actbuf_wr_req = !rst && !fifo_full;
    assign push          = actbuf_wr_vld && actbuf_wr_req;

    ftdnn_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_h     (clk_h),
        .rst       (rst),
        .push      (push),
        .push_data (actbuf_wr_data),
        .pop       (pop),
        .head      (row_wr_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Issue logic: per-row valids, pop decision and next served/ptr.
    always_comb begin
        row_wr_vld = '0;
        pop        = 1'b0;
        served_d   = served_q;
        ptr_d      = ptr_q;
        target     = PTR_W'(next_enabled(MAX_ROWS'(row_en), IDX_W'(ptr_q)));
        if (!rst && !fifo_empty && (row_en != '0)) begin
            if (mode_q == DISP_BCAST) begin
                row_wr_vld = row_en & ~served_q;
                pop        = (((served_q | (row_wr_vld & row_wr_req)) & row_en) == row_en);
                served_d   = pop ? '0 : (served_q | (row_wr_vld & row_wr_req));
            end else begin
                row_wr_vld = NUM_ROWS'(1) << target;
                pop        = |(row_wr_vld & row_wr_req);
                if (pop) begin
                    ptr_d = (target == PTR_W'(NUM_ROWS - 1)) ? '0 : (target + PTR_W'(1));
                end
            end
        end
    end

    // Mode only changes between words so a partially served word never switches policy.
    always_ff @(posedge clk_h) begin
        if (rst) begin
            served_q <= '0;
            ptr_q    <= '0;
            mode_q   <= DISP_BCAST;
        end else begin
            served_q <= served_d;
            ptr_q    <= ptr_d;
            if ((fifo_count == '0) && (served_q == '0)) begin
                mode_q <= dispatch_mode_e'(mode);
            end
        end
    end

    always_ff @(posedge clk_h) begin
        if (rst) begin
            row_param    <= '0;
            row_param_en <= '0;
        end else begin
            row_param_en <= sblk_param_en ? sblk_param_sel : '0;
            if (sblk_param_en) begin
                row_param <= sblk_param;
            end
        end
    end

    // Sticky done bits: a same-cycle set beats the clear.
    always_ff @(posedge clk_h) begin
        if (rst) begin
            sblk_status <= '0;
            all_done    <= 1'b0;
        end else begin
            sblk_status <= row_status | (status_clr ? '0 : sblk_status);
            all_done    <= (row_en != '0) && (&(sblk_status | ~row_en));
        end
    end

`ifdef FTDNN_DISPATCH_PERF_EN
    logic [NUM_ROWS-1:0] accepted;
    assign accepted = row_wr_vld & row_wr_req;

    always_ff @(posedge clk_h) begin
        if (rst || status_clr) begin
            stall_cnt <= '0;
        end else if (!fifo_empty && (accepted == '0) && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + STALL_CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_ftdnn_row_dispatch.sv
// Directed, table-driven bench for ftdnn_row_dispatch (NUM_ROWS=4 defaults).
module tb_ftdnn_row_dispatch;

    logic        clk_h = 1'b0;
    logic        rst;
    logic        mode;
    logic [3:0]  row_en;
    logic [31:0] actbuf_wr_data;
    logic        actbuf_wr_vld;
    logic        actbuf_wr_req;
    logic [31:0] row_wr_data;
    logic [3:0]  row_wr_vld;
    logic [3:0]  row_wr_req;
    logic [63:0] sblk_param;
    logic        sblk_param_en;
    logic [3:0]  sblk_param_sel;
    logic [63:0] row_param;
    logic [3:0]  row_param_en;
    logic [3:0]  row_status;
    logic        status_clr;
    logic [3:0]  sblk_status;
    logic        all_done;
`ifdef FTDNN_DISPATCH_PERF_EN
    logic [31:0] stall_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_h = ~clk_h;

    ftdnn_row_dispatch dut (
        .clk_h          (clk_h),
        .rst            (rst),
        .mode           (mode),
        .row_en         (row_en),
        .actbuf_wr_data (actbuf_wr_data),
        .actbuf_wr_vld  (actbuf_wr_vld),
        .actbuf_wr_req  (actbuf_wr_req),
        .row_wr_data    (row_wr_data),
        .row_wr_vld     (row_wr_vld),
        .row_wr_req     (row_wr_req),
        .sblk_param     (sblk_param),
        .sblk_param_en  (sblk_param_en),
        .sblk_param_sel (sblk_param_sel),
        .row_param      (row_param),
        .row_param_en   (row_param_en),
        .row_status     (row_status),
        .status_clr     (status_clr),
        .sblk_status    (sblk_status),
        .all_done       (all_done)
`ifdef FTDNN_DISPATCH_PERF_EN
        ,
        .stall_cnt      (stall_cnt)
`endif
    );

    typedef struct {
        logic        mode;
        logic [3:0]  en;
        logic        push;
        logic [31:0] data;
        logic [3:0]  req;
        logic        e_req;
        logic [3:0]  e_vld;
        logic [31:0] e_data;
    } dvec_t;

    typedef struct {
        logic        pen;
        logic [3:0]  sel;
        logic [63:0] param;
        logic [3:0]  rstat;
        logic        clr;
        logic [3:0]  en;
        logic [63:0] e_param;
        logic [3:0]  e_pen;
        logic [3:0]  e_status;
        logic        e_done;
    } pvec_t;

    dvec_t dq[$];
    pvec_t pq[$];

    function automatic dvec_t dv(input logic m, input logic [3:0] en, input logic p,
                                 input logic [31:0] d, input logic [3:0] rq, input logic er,
                                 input logic [3:0] ev, input logic [31:0] ed);
        dvec_t v;
        v.mode = m; v.en = en; v.push = p; v.data = d; v.req = rq;
        v.e_req = er; v.e_vld = ev; v.e_data = ed;
        return v;
    endfunction

    function automatic pvec_t pv(input logic pen, input logic [3:0] sel, input logic [63:0] prm,
                                 input logic [3:0] rs, input logic clr, input logic [3:0] en,
                                 input logic [63:0] ep, input logic [3:0] epe,
                                 input logic [3:0] es, input logic ed);
        pvec_t v;
        v.pen = pen; v.sel = sel; v.param = prm; v.rstat = rs; v.clr = clr; v.en = en;
        v.e_param = ep; v.e_pen = epe; v.e_status = es; v.e_done = ed;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_h);
        #1;
    endtask

    initial begin
        // Parameter / status vectors (row_en 1011 unless noted); expectations are
        // the registered outputs seen in the cycle the row is driven.
        pq.push_back(pv(1, 4'h4, 64'h1234, 4'h0, 0, 4'hB, 64'h0,    4'h0, 4'h0, 0));
        pq.push_back(pv(0, 4'h0, 64'h9999, 4'h1, 0, 4'hB, 64'h1234, 4'h4, 4'h0, 0));
        pq.push_back(pv(0, 4'h0, 64'h0,    4'h0, 0, 4'hB, 64'h1234, 4'h0, 4'h1, 0));
        pq.push_back(pv(0, 4'h0, 64'h0,    4'h2, 0, 4'hB, 64'h1234, 4'h0, 4'h1, 0));
        pq.push_back(pv(0, 4'h0, 64'h0,    4'h8, 0, 4'hB, 64'h1234, 4'h0, 4'h3, 0));
        pq.push_back(pv(0, 4'h0, 64'h0,    4'h0, 0, 4'hB, 64'h1234, 4'h0, 4'hB, 0));
        pq.push_back(pv(0, 4'h0, 64'h0,    4'h0, 0, 4'hB, 64'h1234, 4'h0, 4'hB, 1));
        pq.push_back(pv(0, 4'h0, 64'h0,    4'h0, 0, 4'hF, 64'h1234, 4'h0, 4'hB, 1));
        pq.push_back(pv(0, 4'h0, 64'h0,    4'h0, 0, 4'hF, 64'h1234, 4'h0, 4'hB, 0));
        pq.push_back(pv(0, 4'h0, 64'h0,    4'h0, 0, 4'h0, 64'h1234, 4'h0, 4'hB, 0));
        pq.push_back(pv(0, 4'h0, 64'h0,    4'h0, 0, 4'h0, 64'h1234, 4'h0, 4'hB, 0));
        pq.push_back(pv(0, 4'h0, 64'h0,    4'h1, 1, 4'hB, 64'h1234, 4'h0, 4'hB, 0));
        pq.push_back(pv(1, 4'hB, 64'hDEADBEEF00005678, 4'h0, 0, 4'hB, 64'h1234, 4'h0, 4'h1, 1));
        pq.push_back(pv(0, 4'h0, 64'hFFFF, 4'h0, 0, 4'hB, 64'hDEADBEEF00005678, 4'hB, 4'h1, 0));
        pq.push_back(pv(0, 4'h0, 64'h0,    4'h0, 0, 4'hB, 64'hDEADBEEF00005678, 4'h0, 4'h1, 0));

        // Broadcast, all rows ready.
        dq.push_back(dv(0, 4'hF, 1, 32'hA5A5_0001, 4'hF, 1, 4'h0, 32'h0));
        dq.push_back(dv(0, 4'hF, 1, 32'hA5A5_0002, 4'hF, 1, 4'hF, 32'hA5A5_0001));
        dq.push_back(dv(0, 4'hF, 1, 32'hA5A5_0003, 4'hF, 1, 4'hF, 32'hA5A5_0002));
        dq.push_back(dv(0, 4'hF, 1, 32'hA5A5_0004, 4'hF, 1, 4'hF, 32'hA5A5_0003));
        dq.push_back(dv(0, 4'hF, 0, 32'h0,         4'hF, 1, 4'hF, 32'hA5A5_0004));
        dq.push_back(dv(0, 4'hF, 0, 32'h0,         4'hF, 1, 4'h0, 32'h0));
        // Broadcast, row 2 stalls five cycles; FIFO fills and upstream backs off.
        dq.push_back(dv(0, 4'hF, 1, 32'hB000_0001, 4'hB, 1, 4'h0, 32'h0));
        dq.push_back(dv(0, 4'hF, 1, 32'hB000_0002, 4'hB, 1, 4'hF, 32'hB000_0001));
        dq.push_back(dv(0, 4'hF, 1, 32'hB000_0003, 4'hB, 1, 4'h4, 32'hB000_0001));
        dq.push_back(dv(0, 4'hF, 1, 32'hB000_0004, 4'hB, 1, 4'h4, 32'hB000_0001));
        dq.push_back(dv(0, 4'hF, 1, 32'hB000_0005, 4'hB, 0, 4'h4, 32'hB000_0001));
        dq.push_back(dv(0, 4'hF, 1, 32'hB000_0005, 4'hB, 0, 4'h4, 32'hB000_0001));
        dq.push_back(dv(0, 4'hF, 1, 32'hB000_0005, 4'hF, 0, 4'h4, 32'hB000_0001));
        dq.push_back(dv(0, 4'hF, 1, 32'hB000_0005, 4'hF, 1, 4'hF, 32'hB000_0002));
        dq.push_back(dv(0, 4'hF, 0, 32'h0,         4'hF, 1, 4'hF, 32'hB000_0003));
        dq.push_back(dv(0, 4'hF, 0, 32'h0,         4'hF, 1, 4'hF, 32'hB000_0004));
        dq.push_back(dv(0, 4'hF, 0, 32'h0,         4'hF, 1, 4'hF, 32'hB000_0005));
        dq.push_back(dv(0, 4'hF, 0, 32'h0,         4'hF, 1, 4'h0, 32'h0));
        // Scatter over rows 0,1,3 with wrap.
        dq.push_back(dv(1, 4'hB, 1, 32'hC000_0001, 4'hF, 1, 4'h0, 32'h0));
        dq.push_back(dv(1, 4'hB, 1, 32'hC000_0002, 4'hF, 1, 4'h1, 32'hC000_0001));
        dq.push_back(dv(1, 4'hB, 1, 32'hC000_0003, 4'hF, 1, 4'h2, 32'hC000_0002));
        dq.push_back(dv(1, 4'hB, 1, 32'hC000_0004, 4'hF, 1, 4'h8, 32'hC000_0003));
        dq.push_back(dv(1, 4'hB, 1, 32'hC000_0005, 4'hF, 1, 4'h1, 32'hC000_0004));
        dq.push_back(dv(1, 4'hB, 1, 32'hC000_0006, 4'hF, 1, 4'h2, 32'hC000_0005));
        dq.push_back(dv(1, 4'hB, 0, 32'h0,         4'hF, 1, 4'h8, 32'hC000_0006));
        dq.push_back(dv(1, 4'hB, 0, 32'h0,         4'hF, 1, 4'h0, 32'h0));
        // No enabled rows: word stays queued until rows 0 and 2 come up.
        dq.push_back(dv(0, 4'h0, 1, 32'hD000_0001, 4'hF, 1, 4'h0, 32'h0));
        dq.push_back(dv(0, 4'h0, 0, 32'h0,         4'hF, 1, 4'h0, 32'h0));
        dq.push_back(dv(0, 4'h0, 0, 32'h0,         4'hF, 1, 4'h0, 32'h0));
        dq.push_back(dv(0, 4'h5, 0, 32'h0,         4'hF, 1, 4'h5, 32'hD000_0001));
        dq.push_back(dv(0, 4'h5, 0, 32'h0,         4'hF, 1, 4'h0, 32'h0));
        // Row 1 dropped mid-word; mode input toggled while busy must be ignored.
        dq.push_back(dv(0, 4'h3, 1, 32'hE000_0001, 4'h1, 1, 4'h0, 32'h0));
        dq.push_back(dv(1, 4'h3, 0, 32'h0,         4'h1, 1, 4'h3, 32'hE000_0001));
        dq.push_back(dv(1, 4'h3, 0, 32'h0,         4'h0, 1, 4'h2, 32'hE000_0001));
        dq.push_back(dv(1, 4'h1, 1, 32'hF000_0001, 4'h0, 1, 4'h0, 32'h0));
        dq.push_back(dv(0, 4'h1, 0, 32'h0,         4'h1, 1, 4'h1, 32'hF000_0001));
        dq.push_back(dv(0, 4'h1, 0, 32'h0,         4'h1, 1, 4'h0, 32'h0));

        rst = 1'b1; mode = 1'b0; row_en = '0; actbuf_wr_data = '0; actbuf_wr_vld = 1'b0;
        row_wr_req = '0; sblk_param = '0; sblk_param_en = 1'b0; sblk_param_sel = '0;
        row_status = '0; status_clr = 1'b0;
        next_cycle();
        next_cycle();
        @(negedge clk_h);
        check("reset wr_req", 64'(actbuf_wr_req), 64'h0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk_h);
        check("post-reset wr_req", 64'(actbuf_wr_req), 64'h1);
        check("post-reset vld", 64'(row_wr_vld), 64'h0);
        check("post-reset param", row_param, 64'h0);
        check("post-reset param_en", 64'(row_param_en), 64'h0);
        check("post-reset status", 64'(sblk_status), 64'h0);
        check("post-reset all_done", 64'(all_done), 64'h0);
`ifdef FTDNN_DISPATCH_PERF_EN
        check("post-reset stall_cnt", 64'(stall_cnt), 64'h0);
`endif
        next_cycle();

        foreach (pq[i]) begin
            sblk_param_en = pq[i].pen; sblk_param_sel = pq[i].sel; sblk_param = pq[i].param;
            row_status = pq[i].rstat; status_clr = pq[i].clr; row_en = pq[i].en;
            @(negedge clk_h);
            check($sformatf("pv[%0d] row_param", i), row_param, pq[i].e_param);
            check($sformatf("pv[%0d] row_param_en", i), 64'(row_param_en), 64'(pq[i].e_pen));
            check($sformatf("pv[%0d] sblk_status", i), 64'(sblk_status), 64'(pq[i].e_status));
            check($sformatf("pv[%0d] all_done", i), 64'(all_done), 64'(pq[i].e_done));
            next_cycle();
        end
        sblk_param_en = 1'b0; sblk_param_sel = '0; sblk_param = '0;
        row_status = '0; status_clr = 1'b0;

        foreach (dq[i]) begin
            mode = dq[i].mode; row_en = dq[i].en; actbuf_wr_vld = dq[i].push;
            actbuf_wr_data = dq[i].data; row_wr_req = dq[i].req;
            @(negedge clk_h);
            check($sformatf("dv[%0d] wr_req", i), 64'(actbuf_wr_req), 64'(dq[i].e_req));
            check($sformatf("dv[%0d] row_wr_vld", i), 64'(row_wr_vld), 64'(dq[i].e_vld));
            if (dq[i].e_vld != 4'h0) begin
                check($sformatf("dv[%0d] row_wr_data", i), 64'(row_wr_data), 64'(dq[i].e_data));
            end
            next_cycle();
        end

        // Reset mid-stream: scatter leaves ptr at 1 with three words queued.
        mode = 1'b1; row_en = 4'hF; row_wr_req = 4'hF;
        actbuf_wr_vld = 1'b1; actbuf_wr_data = 32'h6000_0001;
        next_cycle();
        actbuf_wr_vld = 1'b0;
        @(negedge clk_h);
        check("mid pre vld", 64'(row_wr_vld), 64'h1);
        next_cycle();
        row_wr_req = 4'h0; actbuf_wr_vld = 1'b1;
        for (int k = 2; k <= 4; k++) begin
            actbuf_wr_data = 32'h6000_0000 + 32'(k);
            next_cycle();
        end
        actbuf_wr_vld = 1'b0;
        @(negedge clk_h);
        check("mid queued vld", 64'(row_wr_vld), 64'h2);
        check("mid queued data", 64'(row_wr_data), 64'h6000_0002);
        next_cycle();
        rst = 1'b1;
        @(negedge clk_h);
        check("mid in-reset wr_req", 64'(actbuf_wr_req), 64'h0);
        check("mid in-reset vld", 64'(row_wr_vld), 64'h0);
        next_cycle();
        rst = 1'b0; row_wr_req = 4'hF;
        @(negedge clk_h);
        check("mid after vld", 64'(row_wr_vld), 64'h0);
        check("mid after wr_req", 64'(actbuf_wr_req), 64'h1);
        next_cycle();
        @(negedge clk_h);
        check("mid no replay vld", 64'(row_wr_vld), 64'h0);
        next_cycle();
        actbuf_wr_vld = 1'b1; actbuf_wr_data = 32'h6000_00AA;
        next_cycle();
        actbuf_wr_vld = 1'b0;
        @(negedge clk_h);
        check("mid ptr0 vld", 64'(row_wr_vld), 64'h1);
        check("mid ptr0 data", 64'(row_wr_data), 64'h6000_00AA);
        next_cycle();
        @(negedge clk_h);
        check("mid drained vld", 64'(row_wr_vld), 64'h0);
        next_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
